// File: rtl/tetris_pkg.sv
// Shared types and constants for the single-cell falling-block game engine.
package tetris_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef logic [COLS-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEARFIELD = 3'd1,
    SPAWN      = 3'd2,
    FALL       = 3'd3,
    LOCK       = 3'd4,
    CHECK      = 3'd5,
    GAMEOVER   = 3'd6
  } state_t;

  localparam logic [1:0] PIX_EMPTY  = 2'd0;
  localparam logic [1:0] PIX_GHOST  = 2'd1;
  localparam logic [1:0] PIX_LOCKED = 2'd2;
  localparam logic [1:0] PIX_ACTIVE = 2'd3;

endpackage

// File: rtl/tetris_drop_engine_fall_tick_gen.sv
// Gravity divider: counts 0..FALL_DIV-1 while enabled, ticks for one cycle on wrap.
module fall_tick_gen #(
  parameter int unsigned FALL_DIV = 800000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FALL_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tetris_drop_engine.sv
// 16x16 playfield with one falling cell: gravity, moves, hard drop, lock,
// row clear, game over, plus a registered pixel port for the matrix scanner.
module tetris_drop_engine
  import tetris_pkg::*;
#(
  parameter int unsigned FALL_DIV  = 800000,
  parameter logic [3:0]  SPAWN_COL = 4'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic [3:0] rd_row,
  input  logic [3:0] rd_col,
  output logic [1:0] rd_pix,
  output logic       game_over,
  output logic [7:0] lines,
  output logic       busy
);

  state_t     state_q, state_d;
  row_t       field_q [ROWS];
  row_t       field_d [ROWS];
  row_t       shifted [ROWS];
  logic [3:0] bx_q, bx_d, by_q, by_d, r_q, r_d;
  logic       drop_q, drop_d;
  logic [7:0] lines_q, lines_d;
  logic [1:0] rd_pix_q, rd_pix_d;
  logic       tick, restart, fall_step;

  fall_tick_gen #(.FALL_DIV(FALL_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .en      (state_q == FALL),
    .tick    (tick)
  );

  // Field as it looks after removing row r_q: everything above moves down one.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_shift
      if (gi == ROWS - 1) begin : g_top
        assign shifted[gi] = '0;
      end else begin : g_body
        assign shifted[gi] = (4'(gi) >= r_q) ? field_q[gi+1] : field_q[gi];
      end
    end
  endgenerate

  assign fall_step = tick || drop_q;

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    bx_d    = bx_q;
    by_d    = by_q;
    r_d     = r_q;
    drop_d  = drop_q;
    lines_d = lines_q;
    restart = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CLEARFIELD;
      CLEARFIELD: begin
        for (int i = 0; i < ROWS; i++) field_d[i] = '0;
        lines_d = '0;
        state_d = SPAWN;
      end
      SPAWN: begin
        if (field_q[ROWS-1][SPAWN_COL]) begin
          state_d = GAMEOVER;
        end else begin
          bx_d    = SPAWN_COL;
          by_d    = 4'd15;
          drop_d  = 1'b0;
          restart = 1'b1;
          state_d = FALL;
        end
      end
      FALL: begin
        if (btn_drop) drop_d = 1'b1;
        if (fall_step) begin
          if (by_q == 4'd0 || field_q[by_q - 4'd1][bx_q]) state_d = LOCK;
          else                                             by_d = by_q - 4'd1;
        end else if (!drop_q && (btn_left != btn_right)) begin
          if (btn_left && bx_q != 4'd0 && !field_q[by_q][bx_q - 4'd1])
            bx_d = bx_q - 4'd1;
          else if (btn_right && bx_q != 4'd15 && !field_q[by_q][bx_q + 4'd1])
            bx_d = bx_q + 4'd1;
        end
      end
      LOCK: begin
        field_d[by_q][bx_q] = 1'b1;
        r_d     = 4'd0;
        state_d = CHECK;
      end
      CHECK: begin
        // A full row is removed and the same index re-examined next cycle.
        if (&field_q[r_q]) begin
          field_d = shifted;
          lines_d = lines_q + 8'd1;
        end else if (r_q == 4'd15) begin
          state_d = SPAWN;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      GAMEOVER: if (start) state_d = CLEARFIELD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_pix_d = PIX_EMPTY;
    if (state_q == FALL && rd_row == by_q && rd_col == bx_q)
      rd_pix_d = PIX_ACTIVE;
    else if (field_q[rd_row][rd_col])
      rd_pix_d = (state_q == GAMEOVER) ? PIX_GHOST : PIX_LOCKED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      for (int i = 0; i < ROWS; i++) field_q[i] <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      r_q      <= '0;
      drop_q   <= 1'b0;
      lines_q  <= '0;
      rd_pix_q <= PIX_EMPTY;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      r_q      <= r_d;
      drop_q   <= drop_d;
      lines_q  <= lines_d;
      rd_pix_q <= rd_pix_d;
    end
  end

  assign rd_pix    = rd_pix_q;
  assign game_over = (state_q == GAMEOVER);
  assign busy      = (state_q == LOCK) || (state_q == CHECK);
  assign lines     = lines_q;

endmodule

// File: tb/tb_tetris_drop_engine.sv
// Directed bench for tetris_drop_engine with FALL_DIV=4, SPAWN_COL=7.
module tb_tetris_drop_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_drop = 1'b0;
  logic [3:0] rd_row = '0;
  logic [3:0] rd_col = '0;
  logic [1:0] rd_pix;
  logic       game_over;
  logic [7:0] lines;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ph;   // expected gravity divider phase while falling
  int eby;  // expected block row while falling
  int bc;
  int n;

  always #5 clk = ~clk;

  tetris_drop_engine #(.FALL_DIV(4), .SPAWN_COL(4'd7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_drop  (btn_drop),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_pix    (rd_pix),
    .game_over (game_over),
    .lines     (lines),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of play: buttons are single-cycle pulses; gravity model advances.
  task automatic fstep();
    step();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
    if (ph == 3) eby--;
    ph = (ph + 1) % 4;
  endtask

  task automatic read_px(input int r, input int c, input logic [1:0] exp, input string tag);
    rd_row = r[3:0];
    rd_col = c[3:0];
    fstep();
    check_eq(tag, rd_pix, exp);
  endtask

  task automatic lock_wait(output int cyc);
    int k;
    k = 0;
    while (!busy && k < 64) begin
      step();
      k++;
    end
    check_eq("lock_reached", busy, 1);
    cyc = 0;
    while (busy && cyc < 64) begin
      cyc++;
      step();
    end
    check_eq("lock_done", busy, 0);
  endtask

  task automatic drop_here(output int cyc);
    btn_drop = 1'b1;
    fstep();
    lock_wait(cyc);
  endtask

  // Starts from SPAWN: walk the new block to column col, then hard drop.
  task automatic drop_at(input int col, output int cyc);
    int cx;
    cx = 7;
    step();
    ph = 0;
    while (cx != col) begin
      if (ph != 3) begin
        if (col < cx) begin btn_left = 1'b1;  cx--; end
        else          begin btn_right = 1'b1; cx++; end
      end
      fstep();
    end
    drop_here(cyc);
    $display("drop col %0d busy_cycles %0d lines %0d", col, cyc, lines);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ph = 0; eby = 15;
    repeat (2) step();
    check_eq("rst_pix", rd_pix, 0);
    check_eq("rst_game_over", game_over, 0);
    check_eq("rst_lines", lines, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Plain gravity from spawn to the floor.
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    ph = 0; eby = 15;
    read_px(15, 7, 3, "spawn_pix");
    n = 0;
    while (!busy && n < 200) begin step(); n++; end
    check_eq("fall_cycles", n, 63);
    lock_wait(bc);
    check_eq("lock_busy_cycles", bc, 17);
    read_px(0, 7, 2, "locked_0_7");
    ph = 0; eby = 15;
    read_px(15, 7, 3, "respawn_15_7");

    // Lateral moves, wall limit, simultaneous left+right.
    n = 0;
    while (n < 8) begin
      if (ph != 3) begin btn_left = 1'b1; n++; end
      fstep();
    end
    read_px(eby, 0, 3, "left8_at_col0");
    while (ph == 3) fstep();
    btn_left = 1'b1; fstep();
    read_px(eby, 0, 3, "left9_stays_col0");
    btn_left = 1'b1; btn_right = 1'b1; fstep();
    read_px(eby, 0, 3, "left_right_ignored");
    while (ph == 3) fstep();
    btn_right = 1'b1; fstep();
    read_px(eby, 1, 3, "right_to_col1");
    read_px(eby, 0, 0, "col0_vacated");
    while (ph == 3) fstep();
    btn_left = 1'b1; fstep();
    read_px(eby, 0, 3, "back_to_col0");
    drop_here(bc);

    // Complete row 0 and clear it.
    for (int c = 1; c < 15; c++) if (c != 7) drop_at(c, bc);
    drop_at(15, bc);
    check_eq("clear_busy_cycles", bc, 18);
    check_eq("lines_after_clear", lines, 1);
    for (int c = 0; c < 16; c++) read_px(0, c, 0, $sformatf("row0_empty_c%0d", c));

    // Cell stacked at (1,7) drops to (0,7) when row 0 clears.
    drop_here(bc);
    drop_at(7, bc);
    for (int c = 0; c < 16; c++) if (c != 7) drop_at(c, bc);
    check_eq("clear2_busy_cycles", bc, 18);
    check_eq("lines_after_clear2", lines, 2);
    read_px(0, 7, 2, "stack_moved_down");
    read_px(1, 7, 0, "stack_vacated");
    read_px(0, 0, 0, "row0_col0_after_clear2");

    // Fill column 7 to the top: next spawn fails.
    drop_here(bc);
    for (int k = 0; k < 14; k++) drop_at(7, bc);
    step();
    check_eq("game_over_set", game_over, 1);
    read_px(0, 7, 1, "ghost_0_7");
    read_px(15, 7, 1, "ghost_15_7");
    read_px(8, 3, 0, "gameover_empty");
    check_eq("gameover_lines", lines, 2);
    check_eq("gameover_busy", busy, 0);

    // Restart from GAMEOVER.
    start = 1'b1; step(); start = 1'b0;
    step();
    check_eq("restart_lines", lines, 0);
    check_eq("restart_game_over", game_over, 0);
    step();
    ph = 0; eby = 15;
    read_px(0, 7, 0, "restart_field_cleared");
    read_px(15, 7, 3, "restart_spawn");

    // Asynchronous reset in the middle of a fall.
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pix", rd_pix, 0);
    check_eq("async_rst_game_over", game_over, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_lines", lines, 0);
    step(); step();
    rst_n = 1'b1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        read_px(r, c, 0, $sformatf("post_rst_r%0d_c%0d", r, c));
    check_eq("post_rst_game_over", game_over, 0);
    check_eq("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_drop_engine.md
Name: tetris_drop_engine

Overview:
- Game-logic stage directly upstream of the 16x16 matrix frame-buffer scanner.
- Owns a 16x16 occupancy playfield and one falling single-cell block; handles fall timing, lateral moves, hard drop, lock, full-row clear and game over.
- Exposes a 1-cycle-latency pixel read port that returns a 2-bit intensity for the scanner's (row, column) lookups.
- Row 0 is the bottom row; row 15 is the top row.

Parameters:
- FALL_DIV, 800000: clk cycles per gravity step (>=2).
- SPAWN_COL, 7: column where a new block appears, in row 15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; starts or restarts a game
- btn_left  in  1  1-cycle pulse, already debounced/synchronised; move block to column-1
- btn_right  in  1  1-cycle pulse; move block to column+1
- btn_drop  in  1  1-cycle pulse; hard drop
- rd_row  in  4  scanner read row
- rd_col  in  4  scanner read column
- rd_pix  out  2  pixel intensity for (rd_row, rd_col) sampled the previous cycle
- game_over  out  1  high while in GAMEOVER
- lines  out  8  rows cleared this game, wraps 255->0
- busy  out  1  high in LOCK/CHECK (playfield being modified)

Behaviour:
- Reset (async, rst_n=0): playfield all 0, state IDLE, rd_pix=0, game_over=0, lines=0, busy=0, divider=0, drop flag=0.
- Storage: field[16] of 16-bit row vectors; block position bx[3:0], by[3:0].
- States:
  - IDLE: wait for start -> CLEARFIELD.
  - CLEARFIELD: 1 cycle; field zeroed, lines=0 -> SPAWN.
  - SPAWN: if field[15][SPAWN_COL] occupied -> GAMEOVER. Else bx=SPAWN_COL, by=15, divider reset, drop flag=0 -> FALL.
  - FALL: divider counts 0..FALL_DIV-1; tick is asserted when it wraps.
    - Fall step occurs on a tick, or every cycle while the drop flag is set.
    - Fall step: if by==0 or field[by-1][bx] occupied -> LOCK; else by-1.
    - In a cycle with a fall step, lateral requests are dropped.
    - Otherwise: btn_left moves to bx-1 if bx>0 and the target cell is free. btn_right moves to bx+1 if bx<15 and the target cell is free.
    - btn_left and btn_right in the same cycle: both ignored.
    - btn_drop sets the drop flag; lateral input is ignored while the flag is set.
  - LOCK: 1 cycle; field[by][bx]=1, scan row r=0 -> CHECK.
  - CHECK: one row per cycle.
    - If field[r]==16'hFFFF: in a single cycle rows r..14 take rows r+1..15, row 15 becomes 0, lines+1; r is rechecked next cycle.
    - Else r+1.
    - After r=15 is checked and not full -> SPAWN.
  - GAMEOVER: game_over=1; start -> CLEARFIELD; buttons ignored.
- start in any state other than IDLE/GAMEOVER is ignored.
- rd_pix is registered, 1-cycle latency, valid in every state:
  - 3: active block at (rd_row, rd_col) in FALL.
  - 2: locked cell, not in GAMEOVER.
  - 1: locked cell in GAMEOVER.
  - 0: otherwise.
  - The field written in cycle N is visible to reads issued in cycle N+1.
- busy = 1 in LOCK and CHECK, else 0.
- All arithmetic is 4-bit unsigned; boundary guards above prevent wrap. by never underflows.
- Reset mid-game returns to IDLE with the field cleared. No partial shift is left.

Decomposition:
- Package tetris_pkg holds:
  - state enum: IDLE, CLEARFIELD, SPAWN, FALL, LOCK, CHECK, GAMEOVER;
  - PIX_EMPTY=0, PIX_GHOST=1, PIX_LOCKED=2, PIX_ACTIVE=3;
  - ROWS=16, COLS=16;
  - row vector typedef logic [15:0].
- Sub-module fall_tick_gen (FALL_DIV counter with synchronous restart, 1-cycle tick output). Instantiated once.

Test Plan:
- FALL_DIV=4, reset then start, no buttons: block appears at (15,7) with rd_pix=3. by reaches 0 after 15 ticks (~60 cycles), then locks. rd_pix(0,7)=2 and the next block is at (15,7).
- btn_left x8 from spawn, with no tick in those cycles: bx=0. A 9th btn_left leaves bx=0. btn_left+btn_right in the same cycle leaves bx unchanged.
- Preload row 0 with columns 0..14 via 15 drops at different columns, then drop at column 15:
  - busy pulses;
  - row 0 reads 0 at every column;
  - lines=1.
- Stack at row 1 column 7 above a full row 0: after the clear, the cell formerly at (1,7) reads 2 at (0,7) and (1,7) reads 0.
- Fill column 7 up to row 15: the next SPAWN enters GAMEOVER with game_over=1 and locked cells reading 1. start clears the field, lines=0, and a new block appears at (15,7).
- Assert rst_n=0 mid-FALL: outputs go to reset values immediately (async). After release the state is IDLE and rd_pix=0 for all addresses.
